// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
//
// Purpose:
//   Sequencer between a UART receiver, a combinational ALU and a UART
//   transmitter. It collects three received bytes in order: operand A,
//   operand B and the opcode. It presents them to the ALU as registered
//   values, captures the ALU result one cycle later and issues a single
//   transmit request. It then waits for the transmitter to finish before
//   it accepts the next command. Bytes that arrive while busy are dropped,
//   and each dropped byte is flagged by rx_overrun.
//
// Optional feature (macro UART_ALU_CTRL_TIMEOUT_EN):
//   When defined, an inter-byte timeout aborts a partially received command
//   after TIMEOUT_CYCLES idle cycles in WAIT_B/WAIT_OP and pulses
//   timeout_tick. When undefined, no counter exists, timeout_tick is tied
//   to 0 and the FSM waits indefinitely.
//
// Parameters:
//   NB_DATA        width of UART bytes, operands and result
//   NB_OP          opcode width (low NB_OP bits of the third byte)
//   TIMEOUT_CYCLES inter-byte timeout in clk cycles (optional feature only)
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   rx_done_tick  in   one-cycle pulse, rx_data holds a new byte
//   rx_data       in   received byte
//   tx_done_tick  in   one-cycle pulse, transmitter finished its byte
//   alu_result    in   combinational ALU output
//   data_a        out  registered operand A
//   data_b        out  registered operand B
//   alu_op        out  registered opcode
//   tx_start      out  one-cycle transmit start (state decode)
//   tx_data       out  registered byte to transmit
//   rx_overrun    out  one-cycle pulse, byte received while busy and dropped
//   timeout_tick  out  one-cycle pulse, command aborted by timeout
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_done_tick,
   input  logic [NB_DATA-1:0] rx_data,
   input  logic               tx_done_tick,
   input  logic [NB_DATA-1:0] alu_result,
   output logic [NB_DATA-1:0] data_a,
   output logic [NB_DATA-1:0] data_b,
   output logic [NB_OP-1:0]   alu_op,
   output logic               tx_start,
   output logic [NB_DATA-1:0] tx_data,
   output logic               rx_overrun,
   output logic               timeout_tick
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      CALC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [NB_DATA-1:0] data_a_q, data_a_d;
   logic [NB_DATA-1:0] data_b_q, data_b_d;
   logic [NB_OP-1:0]   alu_op_q, alu_op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               rx_overrun_q, rx_overrun_d;
   logic               timeout_tick_q, timeout_tick_d;
   logic               expired;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts idle cycles spent in WAIT_B/WAIT_OP. The counter is held at zero
   // in every other state, so it is already clear on entry to WAIT_B.
   // Any received byte restarts the count.
   always_comb begin
      cnt_d = '0;
      if (!rx_done_tick && (state_q == WAIT_B || state_q == WAIT_OP)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign expired = 1'b0;
`endif

   // Next-state and register-update logic.
   always_comb begin
      state_d        = state_q;
      data_a_d       = data_a_q;
      data_b_d       = data_b_q;
      alu_op_d       = alu_op_q;
      tx_data_d      = tx_data_q;
      rx_overrun_d   = 1'b0;
      timeout_tick_d = 1'b0;

      case (state_q)
         WAIT_A: begin
            if (rx_done_tick) begin
               data_a_d = rx_data;
               state_d  = WAIT_B;
            end
         end
         WAIT_B: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_done_tick) begin
               data_b_d = rx_data;
               state_d  = WAIT_OP;
            end else if (expired) begin
               state_d        = WAIT_A;
               timeout_tick_d = 1'b1;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               alu_op_d = rx_data[NB_OP-1:0];
               state_d  = CALC;
            end else if (expired) begin
               state_d        = WAIT_A;
               timeout_tick_d = 1'b1;
            end
         end
         CALC: begin
            // The operand registers were loaded on the previous edge, so the
            // ALU output is valid by the end of this cycle.
            tx_data_d    = alu_result;
            state_d      = SEND;
            rx_overrun_d = rx_done_tick;
         end
         SEND: begin
            state_d      = WAIT_TX;
            rx_overrun_d = rx_done_tick;
         end
         WAIT_TX: begin
            if (tx_done_tick) begin
               state_d = WAIT_A;
            end
            rx_overrun_d = rx_done_tick;
         end
         default: begin
            state_d = WAIT_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= WAIT_A;
         data_a_q       <= '0;
         data_b_q       <= '0;
         alu_op_q       <= '0;
         tx_data_q      <= '0;
         rx_overrun_q   <= 1'b0;
         timeout_tick_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         data_a_q       <= data_a_d;
         data_b_q       <= data_b_d;
         alu_op_q       <= alu_op_d;
         tx_data_q      <= tx_data_d;
         rx_overrun_q   <= rx_overrun_d;
         timeout_tick_q <= timeout_tick_d;
      end
   end

   assign data_a     = data_a_q;
   assign data_b     = data_b_q;
   assign alu_op     = alu_op_q;
   assign tx_data    = tx_data_q;
   assign rx_overrun = rx_overrun_q;
   assign tx_start   = (state_q == SEND);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   assign timeout_tick = timeout_tick_q;
`else
   assign timeout_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;

   logic       clk;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       tx_done_tick;
   logic [7:0] alu_result;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [5:0] alu_op;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       rx_overrun;
   logic       timeout_tick;

   int checks   = 0;
   int failures = 0;

   uart_alu_ctrl #(
      .NB_DATA       (8),
      .NB_OP         (6),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_done_tick(rx_done_tick),
      .rx_data     (rx_data),
      .tx_done_tick(tx_done_tick),
      .alu_result  (alu_result),
      .data_a      (data_a),
      .data_b      (data_b),
      .alu_op      (alu_op),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .rx_overrun  (rx_overrun),
      .timeout_tick(timeout_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Small ALU model: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25.
   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         6'h20: alu_result = data_a + data_b;
         6'h22: alu_result = data_a - data_b;
         6'h24: alu_result = data_a & data_b;
         6'h25: alu_result = data_a | data_b;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      tick();
      rx_done_tick = 1'b0;
   endtask

   task automatic pulse_tx_done();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
   endtask

   // Full command with timing checks; leaves the DUT in WAIT_TX.
   task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
      logic [5:0] op_lo;
      op_lo = op[5:0];
      send_byte(a);
      check({tag, "_a"}, data_a, a);
      check({tag, "_start_b0"}, tx_start, 0);
      send_byte(b);
      check({tag, "_b"}, data_b, b);
      check({tag, "_start_b1"}, tx_start, 0);
      send_byte(op);
      check({tag, "_op"}, alu_op, op_lo);
      check({tag, "_start_calc"}, tx_start, 0);
      tick();
      check({tag, "_start_send"}, tx_start, 1);
      check({tag, "_txdata"}, tx_data, exp);
      tick();
      check({tag, "_start_wait"}, tx_start, 0);
      check({tag, "_txdata_hold"}, tx_data, exp);
      check({tag, "_ovr"}, rx_overrun, 0);
   endtask

   initial begin
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      tx_done_tick = 1'b0;
      tick();
      tick();
      check("rst_data_a", data_a, 0);
      check("rst_data_b", data_b, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_ovr", rx_overrun, 0);
      check("rst_tmo", timeout_tick, 0);
      reset = 1'b0;
      tick();

      // 1: basic ADD
      run_cmd("t1", 8'h05, 8'h03, 8'h20, 8'h08);
      pulse_tx_done();

      // 2: wrapping ADD, then OR with upper opcode bits set, back to back
      run_cmd("t2add", 8'hFF, 8'h01, 8'h20, 8'h00);
      pulse_tx_done();
      run_cmd("t2or", 8'hF0, 8'h0F, 8'hE5, 8'hFF);
      pulse_tx_done();

      // 3: overrun in WAIT_TX, consecutive drops, then a new command
      run_cmd("t3", 8'h12, 8'h34, 8'h24, 8'h10);
      send_byte(8'hAA);
      check("t3_ovr1", rx_overrun, 1);
      check("t3_a_keep", data_a, 8'h12);
      tick();
      check("t3_ovr1_end", rx_overrun, 0);
      send_byte(8'hAB);
      check("t3_ovr2a", rx_overrun, 1);
      send_byte(8'hAC);
      check("t3_ovr2b", rx_overrun, 1);
      check("t3_b_keep", data_b, 8'h34);
      tick();
      check("t3_ovr2_end", rx_overrun, 0);
      // tx_done and rx together in WAIT_TX: byte dropped, back to WAIT_A
      rx_data      = 8'h77;
      rx_done_tick = 1'b1;
      tx_done_tick = 1'b1;
      tick();
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
      check("t3_both_ovr", rx_overrun, 1);
      check("t3_both_a", data_a, 8'h12);
      run_cmd("t3next", 8'h09, 8'h04, 8'h22, 8'h05);
      pulse_tx_done();

      // overrun during CALC
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h20);
      send_byte(8'h55);
      check("calc_ovr", rx_overrun, 1);
      check("calc_start", tx_start, 1);
      check("calc_txdata", tx_data, 8'h05);
      check("calc_a_keep", data_a, 8'h02);
      tick();
      check("calc_ovr_end", rx_overrun, 0);
      pulse_tx_done();

      // 4: reset mid-command
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t4_data_a", data_a, 0);
      check("t4_data_b", data_b, 0);
      check("t4_alu_op", alu_op, 0);
      check("t4_tx_data", tx_data, 0);
      check("t4_tx_start", tx_start, 0);
      check("t4_ovr", rx_overrun, 0);
      run_cmd("t4", 8'h01, 8'h02, 8'h22, 8'hFF);
      pulse_tx_done();

      // 5: tx_done_tick in WAIT_A and WAIT_B is ignored
      pulse_tx_done();
      check("t5_waita_start", tx_start, 0);
      send_byte(8'h06);
      pulse_tx_done();
      check("t5_waitb_start", tx_start, 0);
      check("t5_waitb_b", data_b, 8'h02);
      send_byte(8'h07);
      check("t5_b", data_b, 8'h07);
      send_byte(8'h20);
      tick();
      check("t5_start", tx_start, 1);
      check("t5_txdata", tx_data, 8'h0D);
      tick();
      pulse_tx_done();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
      // 6: timeout after 100 idle cycles in WAIT_B
      begin
         int early;
         early = 0;
         send_byte(8'h07);
         for (int i = 0; i < 99; i++) begin
            tick();
            if (timeout_tick !== 1'b0) early++;
         end
         check("t6_no_early_tmo", early, 0);
         tick();
         check("t6_tmo", timeout_tick, 1);
         check("t6_a_keep", data_a, 8'h07);
         tick();
         check("t6_tmo_end", timeout_tick, 0);
      end
      run_cmd("t6", 8'h01, 8'h01, 8'h20, 8'h02);
      pulse_tx_done();
      // byte on the expiry cycle wins
      send_byte(8'h07);
      for (int i = 0; i < 99; i++) tick();
      send_byte(8'h09);
      check("t6_exp_tmo", timeout_tick, 0);
      check("t6_exp_b", data_b, 8'h09);
      send_byte(8'h20);
      tick();
      check("t6_exp_start", tx_start, 1);
      check("t6_exp_txdata", tx_data, 8'h10);
      tick();
      pulse_tx_done();
`else
      // Without the timeout, WAIT_B waits indefinitely
      begin
         int seen;
         seen = 0;
         send_byte(8'h07);
         for (int i = 0; i < 120; i++) begin
            tick();
            if (timeout_tick !== 1'b0) seen++;
         end
         check("nt_no_tmo", seen, 0);
      end
      send_byte(8'h01);
      check("nt_b", data_b, 8'h01);
      send_byte(8'h20);
      tick();
      check("nt_start", tx_start, 1);
      check("nt_txdata", tx_data, 8'h08);
      tick();
      pulse_tx_done();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencer between the UART receiver, the combinational ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the ALU, captures the ALU result and hands it to the transmitter as one byte.
- Then waits for transmission to finish before accepting the next command.

Parameters:
NB_DATA, 8, width of UART bytes, operands and result
NB_OP, 6, opcode width; low NB_OP bits of the third byte
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_done_tick  input  1  one-cycle pulse: rx_data holds a new byte
rx_data  input  NB_DATA  received byte from UART receiver
tx_done_tick  input  1  one-cycle pulse: transmitter finished the current byte
alu_result  input  NB_DATA  combinational ALU output for data_a/data_b/alu_op
data_a  output  NB_DATA  registered operand A to ALU
data_b  output  NB_DATA  registered operand B to ALU
alu_op  output  NB_OP  registered opcode to ALU
tx_start  output  1  one-cycle start pulse to transmitter
tx_data  output  NB_DATA  registered byte to transmit
rx_overrun  output  1  one-cycle pulse: byte received while busy, dropped
timeout_tick  output  1  one-cycle pulse: command aborted by timeout (0 without feature)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on posedge clk.
- Reset values: state=WAIT_A; data_a, data_b, alu_op, tx_data = 0; tx_start, rx_overrun, timeout_tick = 0.
- Reset mid-operation: aborts any partial command; no tx_start is issued afterwards.
- FSM states and transitions:
  - WAIT_A: on rx_done_tick, data_a<=rx_data, go to WAIT_B.
  - WAIT_B: on rx_done_tick, data_b<=rx_data, go to WAIT_OP.
  - WAIT_OP: on rx_done_tick, alu_op<=rx_data[NB_OP-1:0], go to CALC.
  - CALC: exactly one cycle; ALU settles on the new registers. tx_data<=alu_result, go to SEND.
  - SEND: exactly one cycle; tx_start=1 (decoded from state). Go to WAIT_TX.
  - WAIT_TX: on tx_done_tick, go to WAIT_A.
- Latency: rx_done_tick of the opcode byte in cycle N -> state CALC in N+1 -> tx_start high in cycle N+2 only, with tx_data already valid and held stable until the next CALC.
- data_a, data_b and alu_op hold their values until overwritten by the next command.
- Upper rx_data bits above NB_OP are discarded for the opcode. No arithmetic is done in this block.
- Busy overrun: an rx_done_tick while in CALC, SEND or WAIT_TX:
  - the byte is dropped and no register changes;
  - rx_overrun is high for exactly the following cycle;
  - consecutive drops give consecutive pulses.
- tx_done_tick outside WAIT_TX is ignored.
- rx_done_tick and tx_done_tick together in WAIT_TX: go to WAIT_A, the byte is dropped and rx_overrun pulses.
- All outputs are glitch-free registered values, except tx_start, which is a state decode.

Optional Feature:
UART_ALU_CTRL_TIMEOUT_EN
- With the macro defined:
  - A counter of ceil(log2(TIMEOUT_CYCLES)) bits clears on entry to WAIT_B or WAIT_OP and on every rx_done_tick.
  - It increments each cycle while in WAIT_B or WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done_tick that cycle, the state goes to WAIT_A and timeout_tick pulses for the following cycle.
  - Already-latched data_a/data_b keep their values.
  - rx_done_tick in the same cycle as expiry wins: the byte is accepted normally.
- Without the macro: no counter is synthesized, timeout_tick is tied to 0, and WAIT_B/WAIT_OP wait indefinitely.

Test Plan:
1. Send bytes 0x05, 0x03, 0x20 with a model ALU returning A+B -> data_a=0x05, data_b=0x03, alu_op=0x20; tx_start exactly 2 cycles after the third rx_done_tick with tx_data=0x08; tx_done_tick returns to WAIT_A.
2. Send 0xFF, 0x01, 0x20 (ADD wraps) -> tx_data=0x00; then 0xF0, 0x0F, 0x25 (OR) -> tx_data=0xFF. Verify back-to-back commands without reset.
3. Send a fourth byte 0xAA while in WAIT_TX -> rx_overrun pulses 1 cycle, data_a unchanged; the next command after tx_done_tick is processed correctly.
4. Send 0x11, 0x22, then assert reset for 1 cycle; then send 0x01, 0x02, 0x22 -> all outputs 0 after reset; no tx_start before the new opcode; tx_data=ALU(0x01, 0x02, SUB)=0xFF.
5. tx_done_tick pulsed in WAIT_A and WAIT_B -> no state change and no tx_start.
6. (TIMEOUT_EN, TIMEOUT_CYCLES=100) Send 0x07, then idle for 100 cycles -> timeout_tick pulses once and the state is WAIT_A. Then send 0x01, 0x01, 0x20 -> tx_data=0x02. Repeat with a byte arriving on the expiry cycle -> it is accepted and no timeout occurs.
